isp_stream_checker: RTL
=======================

// Module: isp_stream_checker
// PURPOSE
//  Synthesizable scoreboard for the ISP RGB pixel stream (demosaic/denoise/white-balance output format).
//  Compares each R/G/B beat against a golden ROM, enforces R->G->B beat order, and checks column/picture flags.
//  Counts errors and reports done/pass. Used in on-FPGA self-test and as the bench checker.
// PARAMETERS
//  COLOR_DEPTH  8     bits per colour sample
//  PIX_PER_COL  16    pixels per column group; last_col_in is due on the final pixel of each group
//  NUM_PIXELS   32    pixels per picture (each pixel = 3 beats R,G,B)
//  ERR_W        16    error counter width (saturating)
//  TIMEOUT      1024  idle cycles before a stall error (only with ISP_CHK_TIMEOUT_EN)
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  pixel_in     in   COLOR_DEPTH  sample under test
//  valid_in     in   1            beat valid, one beat per cycle max
//  color_in     in   2            0=R 1=G 2=B 3=VOID
//  last_col_in  in   1            last pixel of column group
//  last_pic_in  in   1            last pixel of picture
//  gold_addr    out  clog2(NUM_PIXELS)  pixel index into golden ROM (registered)
//  gold_r/g/b   in   COLOR_DEPTH  golden samples at gold_addr, combinational read, valid same cycle
//  err_pulse    out  1            1-cycle pulse per beat with >=1 error
//  err_code     out  4            {order,flag,data,void} bits of that beat, held until next error
//  err_count    out  ERR_W        total errors, saturates at all-ones
//  done         out  1            sticky, picture fully checked
//  pass         out  1            done && err_count==0
// BEHAVIOUR
//  - Reset: gold_addr=0, err_pulse=0, err_code=0, err_count=0, done=0, pass=0, FSM=EXP_R.
//  - FSM EXP_R -> EXP_G -> EXP_B -> EXP_R, advances only on valid_in beats; ignores valid_in=0 cycles.
//  - Per beat, evaluated in the valid cycle, results registered (1-cycle latency on err_*):
//    * void:  color_in==3 -> +1; FSM does not advance, no data compare.
//    * order: color_in != expected -> +1; FSM resyncs to successor of color_in (R->G, G->B, B->R).
//    * data:  pixel_in != gold_{color_in} -> +1 (compared against received colour, even on order error).
//    * flag:  on B beat, last_col_in must equal (gold_addr % PIX_PER_COL == PIX_PER_COL-1),
//             last_pic_in must equal (gold_addr == NUM_PIXELS-1); on R/G beats both must be 0. Any mismatch +1.
//    * Errors of one beat summed (max 4 added per beat); counter saturates, never wraps.
//  - gold_addr increments after every B beat (including B beats with errors); wraps to 0 after NUM_PIXELS-1.
//  - done sets after the B beat of pixel NUM_PIXELS-1, or on any B beat with last_pic_in=1 (early end:
//    counts one flag error if gold_addr != NUM_PIXELS-1). After done, further beats are checked for next picture
//    from gold_addr=0; done/pass remain sticky until reset.
//  - Beats while done and before next valid do not clear err_count.
//  - Reset mid-picture: all state returns to reset values immediately (async), no partial result kept.
// CONFIGURATION
//  ISP_CHK_TIMEOUT_EN defined: idle counter clears on each valid beat, runs while !done and at least one beat
//   seen; reaching TIMEOUT cycles raises one error (err_code=4'b0000 plus err_pulse), sets done, pass=0, counter stops.
//  Not defined: no idle counter; a stalled stream leaves done=0 indefinitely.
// TESTING
//  1 Clean picture, 96 beats R,G,B matching ROM, flags per rule -> err_count=0, done=1, pass=1 after beat 96.
//  2 Pixel 5 G beat = gold_g+1 -> single err_pulse, err_code=4'b0010, err_count=1, pass=0.
//  3 Beats R,B,R,G,B (G dropped) -> order error on B, FSM resyncs, gold_addr=1 after 1st B, err_count=1 (+data if mismatch).
//  4 last_col_in omitted on pixel 15 B beat and asserted on pixel 16 R beat -> err_count=2, code flag bit each.
//  5 color_in=3 beat mid-picture -> void error, FSM unchanged, following correct beats error-free, err_count=1.
//  6 ISP_CHK_TIMEOUT_EN, TIMEOUT=1024: stop stream after 40 beats -> after 1024 idle cycles err_count=1, done=1, pass=0;
//    without macro done stays 0. Also assert rst_n mid-picture -> all outputs 0 next edge.

Source files
------------

// File: rtl/isp_stream_checker.sv
// -----------------------------------------------------------------------------
// isp_stream_checker
//   Scoreboard for the ISP RGB pixel stream. Each R/G/B beat is compared
//   against a golden ROM addressed by gold_addr. The checker also enforces
//   R->G->B beat order and checks the column/picture flags. Errors are counted
//   with saturation, and done/pass are reported.
//
//   Optional feature macro: ISP_CHK_TIMEOUT_EN enables an idle watchdog. Once
//   the stream has started and the picture is not yet done, TIMEOUT idle
//   cycles raise one error and set done.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   pixel_in     sample under test
//   valid_in     beat valid (at most one beat per cycle)
//   color_in     0=R 1=G 2=B 3=VOID
//   last_col_in  last pixel of a column group (due on the B beat)
//   last_pic_in  last pixel of the picture (due on the B beat)
//   gold_addr    registered pixel index into the golden ROM
//   gold_r/g/b   golden samples at gold_addr (combinational ROM read)
//   err_pulse    one-cycle pulse for each beat that has at least one error
//   err_code     {order,flag,data,void} of the last erroneous beat
//   err_count    total errors, saturating
//   done, pass   sticky picture-complete flag, and done with zero errors
//   fsm_state    expected colour of the next beat (0=R 1=G 2=B), for debug
//
// Handshake: a beat is transferred in every cycle with valid_in=1. There is
// no back-pressure, so the checker accepts every beat it is given.
// -----------------------------------------------------------------------------
module isp_stream_checker #(
   parameter int COLOR_DEPTH = 8,
   parameter int PIX_PER_COL = 16,
   parameter int NUM_PIXELS  = 32,
   parameter int ERR_W       = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [COLOR_DEPTH-1:0]        pixel_in,
   input  logic                          valid_in,
   input  logic [1:0]                    color_in,
   input  logic                          last_col_in,
   input  logic                          last_pic_in,
   output logic [$clog2(NUM_PIXELS)-1:0] gold_addr,
   input  logic [COLOR_DEPTH-1:0]        gold_r,
   input  logic [COLOR_DEPTH-1:0]        gold_g,
   input  logic [COLOR_DEPTH-1:0]        gold_b,
   output logic                          err_pulse,
   output logic [3:0]                    err_code,
   output logic [ERR_W-1:0]              err_count,
   output logic                          done,
   output logic                          pass,
   output logic [1:0]                    fsm_state
);

   localparam int AW = $clog2(NUM_PIXELS);

   typedef enum logic [1:0] {EXP_R = 2'd0, EXP_G = 2'd1, EXP_B = 2'd2} state_t;
   state_t state;

   logic                   is_void, beat, is_b;
   logic                   col_last, pic_last;
   logic                   order_err, data_err, flag_err;
   logic                   timeout_hit;
   logic                   err_any, done_next;
   logic [3:0]             err_vec;
   logic [2:0]             add;
   logic [ERR_W:0]         sum;
   logic [ERR_W-1:0]       count_next;
   logic [AW-1:0]          addr_next;
   logic [COLOR_DEPTH-1:0] gold_sel;

   assign fsm_state = state;

   // A void beat only counts as a void error. It skips the order, data and
   // flag checks and does not move the FSM.
   assign is_void = valid_in && (color_in == 2'd3);
   assign beat    = valid_in && (color_in != 2'd3);
   assign is_b    = beat && (color_in == 2'd2);

   assign col_last = ((32'(gold_addr) % PIX_PER_COL) == PIX_PER_COL - 1);
   assign pic_last = (32'(gold_addr) == NUM_PIXELS - 1);

   // Data is compared against the colour actually received, so a misordered
   // beat is still checked for data correctness.
   always_comb begin
      gold_sel = gold_b;
      case (color_in)
         2'd0:    gold_sel = gold_r;
         2'd1:    gold_sel = gold_g;
         default: gold_sel = gold_b;
      endcase
   end

   assign order_err = beat && (color_in != fsm_state);
   assign data_err  = beat && (pixel_in != gold_sel);
   assign flag_err  = beat && ((last_col_in != (is_b && col_last)) ||
                               (last_pic_in != (is_b && pic_last)));
   assign err_vec   = {order_err, flag_err, data_err, is_void};

`ifdef ISP_CHK_TIMEOUT_EN
   logic [$clog2(TIMEOUT+1)-1:0] idle_cnt;
   logic                         seen;

   assign timeout_hit = !valid_in && seen && !done && (32'(idle_cnt) == TIMEOUT - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
         seen     <= 1'b0;
      end else if (valid_in) begin
         idle_cnt <= '0;
         seen     <= 1'b1;
      end else if (seen && !done && !timeout_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   // The watchdog is compiled out. This evaluates to 0 for any legal TIMEOUT.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   // A timeout only fires on idle cycles, so it never coincides with beat
   // errors. Its err_code is therefore all zeros.
   assign err_any = (|err_vec) || timeout_hit;
   assign add     = {2'b00, err_vec[0]} + {2'b00, err_vec[1]} + {2'b00, err_vec[2]} +
                    {2'b00, err_vec[3]} + {2'b00, timeout_hit};
   assign sum        = {1'b0, err_count} + {{(ERR_W-2){1'b0}}, add};
   assign count_next = sum[ERR_W] ? '1 : sum[ERR_W-1:0];

   // An early last_pic_in also ends the picture. Its flag error is already
   // counted by the flag check above.
   assign done_next = done || (is_b && (pic_last || last_pic_in)) || timeout_hit;

   always_comb begin
      addr_next = gold_addr;
      if (is_b) begin
         if (pic_last || last_pic_in) addr_next = '0;
         else                         addr_next = gold_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EXP_R;
         gold_addr <= '0;
         err_pulse <= 1'b0;
         err_code  <= 4'b0000;
         err_count <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         // Every non-void beat resyncs the FSM to the successor of the
         // received colour. On a correct beat this is the normal advance.
         if (beat) begin
            case (color_in)
               2'd0:    state <= EXP_G;
               2'd1:    state <= EXP_B;
               default: state <= EXP_R;
            endcase
         end
         gold_addr <= addr_next;
         err_pulse <= err_any;
         if (err_any) err_code <= err_vec;
         err_count <= count_next;
         done      <= done_next;
         pass      <= done_next && (count_next == '0);
      end
   end

endmodule
